// File: rtl/etapa_condicion_banderas_if.sv
// rtl/etapa_condicion_banderas_if.sv - ALU-to-writeback handshake and payload bundle for the condition/flags stage
interface etapa_condicion_banderas_if #(
    parameter int N     = 32,
    parameter int CNT_W = 16
);
    logic             valid_in;
    logic             ready_in;
    logic [N-1:0]     resultado;
    logic             flag_n_in;
    logic             flag_z_in;
    logic             flag_v_in;
    logic             flag_c_in;
    logic [3:0]       cond;
    logic             set_flags;
    logic             reg_write_in;
    logic [3:0]       rd_in;
    logic             valid_out;
    logic             ready_out;
    logic [N-1:0]     resultado_out;
    logic [3:0]       rd_out;
    logic             reg_write_out;
    logic             cond_pass_out;
    logic [3:0]       nzcv;
    logic [CNT_W-1:0] annulled_count;

    modport master (
        output valid_in, resultado, flag_n_in, flag_z_in, flag_v_in, flag_c_in,
               cond, set_flags, reg_write_in, rd_in, ready_out,
        input  ready_in, valid_out, resultado_out, rd_out, reg_write_out,
               cond_pass_out, nzcv, annulled_count
    );

    modport slave (
        input  valid_in, resultado, flag_n_in, flag_z_in, flag_v_in, flag_c_in,
               cond, set_flags, reg_write_in, rd_in, ready_out,
        output ready_in, valid_out, resultado_out, rd_out, reg_write_out,
               cond_pass_out, nzcv, annulled_count
    );
endinterface

// File: rtl/etapa_condicion_banderas.sv
// rtl/etapa_condicion_banderas.sv - execute back end: condition evaluation, NZCV register, writeback pipeline slot
module etapa_condicion_banderas #(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    etapa_condicion_banderas_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic             valid_q, valid_d;
    logic [N-1:0]     res_q, res_d;
    logic [3:0]       rd_q, rd_d;
    logic             rw_q, rw_d;
    logic             pass_q, pass_d;
    logic [3:0]       nzcv_q, nzcv_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic ready;
    logic accept;
    logic pass;
    logic fn, fz, fc, fv;

    assign fn = nzcv_q[3];
    assign fz = nzcv_q[2];
    assign fc = nzcv_q[1];
    assign fv = nzcv_q[0];

    // Evaluated against the architectural register only, never the incoming ALU flags.
    always_comb begin
        pass = 1'b0;
        unique case (bus.cond)
            4'b0000: pass = fz;
            4'b0001: pass = !fz;
            4'b0010: pass = fc;
            4'b0011: pass = !fc;
            4'b0100: pass = fn;
            4'b0101: pass = !fn;
            4'b0110: pass = fv;
            4'b0111: pass = !fv;
            4'b1000: pass = fc && !fz;
            4'b1001: pass = !fc || fz;
            4'b1010: pass = (fn == fv);
            4'b1011: pass = (fn != fv);
            4'b1100: pass = !fz && (fn == fv);
            4'b1101: pass = fz || (fn != fv);
            4'b1110: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

    assign ready  = !valid_q || bus.ready_out;
    assign accept = bus.valid_in && ready;

    always_comb begin
        valid_d = valid_q;
        res_d   = res_q;
        rd_d    = rd_q;
        rw_d    = rw_q;
        pass_d  = pass_q;
        nzcv_d  = nzcv_q;
        cnt_d   = cnt_q;
        if (accept) begin
            valid_d = 1'b1;
            res_d   = bus.resultado;
            rd_d    = bus.rd_in;
            pass_d  = pass;
            rw_d    = bus.reg_write_in && pass;
            // Flags commit at accept so the very next instruction is evaluated against them.
            if (pass && bus.set_flags) begin
                nzcv_d = {bus.flag_n_in, bus.flag_z_in, bus.flag_c_in, bus.flag_v_in};
            end
            if (!pass) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (valid_q && bus.ready_out) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
            pass_q  <= 1'b0;
            nzcv_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            res_q   <= res_d;
            rd_q    <= rd_d;
            rw_q    <= rw_d;
            pass_q  <= pass_d;
            nzcv_q  <= nzcv_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ready_in       = ready;
    assign bus.valid_out      = valid_q;
    assign bus.resultado_out  = res_q;
    assign bus.rd_out         = rd_q;
    assign bus.reg_write_out  = rw_q;
    assign bus.cond_pass_out  = pass_q;
    assign bus.nzcv           = nzcv_q;
    assign bus.annulled_count = cnt_q;
endmodule

// File: doc/etapa_condicion_banderas.md
Name: etapa_condicion_banderas

Overview:
- Execute-stage back end; sits directly downstream of the 32-bit ALU.
- Captures the ALU result and its four raw flags (N, Z, V, C) into a single-entry valid/ready pipeline register toward writeback.
- Holds the architectural NZCV status register.
- Evaluates each instruction's 4-bit ARM condition field against the current NZCV. Suppresses register write and flag update for failed instructions, and counts annulled instructions.

Parameters:
- N, 32, data width of result (matches ALU width)
- CNT_W, 16, width of annulled-instruction counter

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- valid_in  input  1  upstream (ALU stage) has an instruction
- ready_in  output  1  stage can accept this cycle
- resultado  input  N  ALU result
- flag_n_in  input  1  ALU negative flag
- flag_z_in  input  1  ALU zero flag
- flag_v_in  input  1  ALU overflow flag
- flag_c_in  input  1  ALU carry flag
- cond  input  4  ARM condition field
- set_flags  input  1  S bit: update NZCV if condition passes
- reg_write_in  input  1  instruction writes a destination register
- rd_in  input  4  destination register index
- valid_out  output  1  registered instruction available to writeback
- ready_out  input  1  writeback can accept
- resultado_out  output  N  registered result
- rd_out  output  4  registered destination index
- reg_write_out  output  1  reg_write_in AND condition pass (registered)
- cond_pass_out  output  1  registered condition-pass bit
- nzcv  output  4  status register {N,Z,C,V}, bit 3 = N
- annulled_count  output  CNT_W  count of accepted instructions that failed their condition

Behaviour:
- Reset (async, rst_n=0): valid_out=0, resultado_out=0, rd_out=0, reg_write_out=0, cond_pass_out=0, nzcv=4'b0000, annulled_count=0.
- Reset is effective immediately. Any instruction in flight is dropped.
- First acceptance is possible on the first rising edge after deassertion.
- ready_in = !valid_out || ready_out (combinational). accept = valid_in && ready_in.
- Condition pass is combinational from cond and the current registered nzcv. It never uses the incoming flags.
  - 0000 EQ: Z; 0001 NE: !Z
  - 0010 CS: C; 0011 CC: !C
  - 0100 MI: N; 0101 PL: !N
  - 0110 VS: V; 0111 VC: !V
  - 1000 HI: C&!Z; 1001 LS: !C|Z
  - 1010 GE: N==V; 1011 LT: N!=V
  - 1100 GT: !Z&(N==V); 1101 LE: Z|(N!=V)
  - 1110 AL: 1; 1111: 0 (never)
- On accept, one cycle latency:
  - valid_out<=1; resultado_out, rd_out <= inputs.
  - cond_pass_out <= pass; reg_write_out <= reg_write_in & pass.
- Failed instructions still propagate as valid with reg_write_out=0.
- NZCV update: on accept with pass && set_flags, nzcv <= {flag_n_in, flag_z_in, flag_c_in, flag_v_in}. Otherwise nzcv holds.
- NZCV is written at accept time, not at output handoff. A back-to-back dependent instruction accepted on the next cycle sees the updated nzcv.
- If valid_out && ready_out && !accept: valid_out<=0. Data registers hold their last values.
- Simultaneous drain and accept: the register is overwritten with the new instruction and valid_out stays 1. No bubble.
- valid_out && !ready_out: all outputs and nzcv hold and ready_in=0. Upstream values are ignored even if valid_in=1.
- annulled_count: increments by 1 on each accept with pass=0. Wraps from 2^CNT_W-1 to 0.
- Data, rd and flags are don't-care when valid_in=0. No state change occurs without accept.

Test Plan:
- Reset then nzcv=0000. Accept cond=1110, S=1, resultado=0, Z=1, others 0 → next cycle valid_out=1, reg_write_out=1, nzcv=0100.
- With nzcv=0100: cond=0001 (NE), reg_write_in=1, rd=5 → cond_pass_out=0, reg_write_out=0, rd_out=5, annulled_count 0→1, nzcv unchanged.
- Back-to-back:
  - cycle k: cond=AL, S=1, N=1, V=0.
  - cycle k+1: cond=1011 (LT), S=1, Z=1.
  - Response: second instruction passes; nzcv=1000 after k, then 0100 after k+1.
- Backpressure: ready_out=0 for 3 cycles with valid_in=1 and changing data → ready_in=0, resultado_out stable, nzcv stable. On release, the held instruction drains and the next one is accepted in the same cycle.
- cond=1111 with S=1, flags 1111 → pass=0, nzcv unchanged, annulled_count+1. Also preset the counter to 0xFFFF via 65535 annulled instructions → the next one wraps to 0x0000.
- Assert rst_n=0 mid-stream while valid_out=1 and nzcv=1010 → outputs zero immediately, before any clock edge.
